bus8051_fir: RTL and testbench
==============================

Name: bus8051_fir

Overview:
- Parametrised successor to the single-channel TH99CHLS filter front end: an 8051 multiplexed-bus slave with a TAPS-deep sample delay line and a sequential masked FIR MAC engine.
- CPU configures coefficients, tap mask and control over the bus, and reads back status and the result.
- Samples arrive on the pe_n/sig_in strobe; each accepted sample triggers one filter evaluation.
- Sits between the sample input port and the display/output logic.

Parameters:
- TAPS, 8, number of taps/coefficients; legal range 1..16.
- DW, 8, sample width (unsigned); legal range 1..12.
- CW, 8, coefficient width (unsigned); legal range 1..8.
- BASE_HI, 8'h00, value abus must carry during address phase for the block to decode.
- OW, DW+CW+4, result width (derived, ≤32; not user-set).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- cs_n  in  1  chip select, active low.
- abus  in  8  address high byte.
- ale  in  1  address latch enable; address captured on its falling edge.
- r_n  in  1  read strobe, active low.
- w_n  in  1  write strobe; commit on rising edge.
- dbus_in  in  8  address low byte (address phase) / write data.
- dbus_out  out  8  read data.
- dbus_oe  out  1  read-data drive enable.
- pe_n  in  1  sample strobe, active low, one clk wide.
- sig_in  in  DW  sample value.
- y  out  OW  last filter result.
- y_valid  out  1  one-cycle pulse when y updates.
- busy  out  1  MAC in progress.

Behaviour:
- Reset (rst=1 at clk edge): coef[*]=0, mask=0, ctrl.enable=1, history=0, overrun=0, rvalid=0, y=0, y_valid=0, busy=0, dbus_oe=0, dbus_out=0, FSM=IDLE, latched address=0. Reset mid-MAC aborts; no y_valid pulse is issued.
- Bus edges are detected by registering ale, w_n and r_n one cycle, all qualified by cs_n=0.
- Address phase: while ale=1, {abus,dbus_in} is registered each cycle; on the ale 1->0 edge the last registered value becomes the latched address.
- Decode requires latched address[15:8]==BASE_HI; otherwise writes are ignored and dbus_oe stays 0.
- Write: on the w_n 0->1 edge, dbus_in (value from the previous cycle) is written to the latched register.
- Read: while cs_n=0 and r_n=0, dbus_oe=1 and dbus_out=reg[addr], registered (1-cycle latency from r_n falling).
- Address map (low byte):
  - 0x00..TAPS-1: coef[k], R/W, low CW bits significant, upper bits read 0.
  - 0x20 / 0x21: mask[7:0] / mask[15:8], R/W; bits ≥TAPS read 0.
  - 0x22 CTRL:
    - bit0 enable, R/W.
    - bit1 clear_history, W1 self-clears; zeroes history next cycle.
    - bit2 clear_overrun, W1.
  - 0x23 STATUS, RO: bit0 busy, bit1 overrun, bit2 rvalid.
  - 0x24..0x27: y bytes 0..3, RO, zero-extended. A read of 0x24 clears rvalid.
  - Unmapped addresses read 0x00.
- Sample accept: pe_n=0 with enable=1 and FSM=IDLE shifts the history (x[0]<=sig_in, x[k]<=x[k-1]), clears the accumulator and enters MAC next cycle.
  - pe_n=0 with enable=0: ignored, no overrun.
  - pe_n=0 while busy: sample dropped, overrun<=1 (sticky).
- FSM:
  - IDLE -> MAC on accept.
  - MAC: one tap per cycle, k=0..TAPS-1; acc += mask[k] ? coef[k]*x[k] : 0; busy=1.
  - After k=TAPS-1: DONE.
  - DONE: y<=acc, y_valid=1 for one cycle, rvalid<=1, then IDLE.
  - Latency: y_valid asserts TAPS+2 cycles after the pe_n cycle.
- Coefficient/mask writes during MAC take effect immediately; tap k uses the register value present in MAC cycle k.
- clear_history during MAC is honoured after DONE, and the current result completes.
- Simultaneous clear_overrun write and new overrun: overrun stays 1.
- Arithmetic is unsigned and OW-wide; it cannot overflow within legal parameter ranges.

Test Plan (TAPS=8, DW=CW=8, BASE_HI=0):
- Readback: write 0xA5 to 0x0003, read 0x0003 -> 0xA5; read 0x0030 -> 0x00; write with abus=0x01 -> register unchanged.
- Basic FIR: coef0..3 = 1,2,3,4, mask=0x000F; samples 65 then 66, 67, 68 (100 ns apart).
  - First result y=65.
  - Final result y=660, y_valid exactly TAPS+2 cycles after the pe_n cycle.
  - Bytes 0x24/0x25 read 0x94/0x02.
- Mask: same history, mask=0x0005, new sample 0 after clear_history -> y=0; rerun with history 68,67,66,65 -> y=266.
- Overrun: two pe_n pulses 2 cycles apart -> one y_valid only; STATUS=0x06 after completion; write CTRL bit2 (keeping enable) -> STATUS bit1=0.
- Enable: CTRL=0x00, pulse pe_n -> no busy, no y_valid, no overrun, history unchanged.
- Reset mid-MAC: assert rst in MAC cycle 3 -> no y_valid; all outputs zero; CTRL reads 0x01 afterward.

Source files
------------

// File: rtl/bus8051_fir_if.sv
// 8051-style multiplexed bus between the CPU and the FIR front end.
//   cs_n     chip select, active low
//   abus     address high byte
//   ale      address latch enable (address taken on its falling edge)
//   r_n      read strobe, active low
//   w_n      write strobe, data committed on its rising edge
//   dbus_in  address low byte during the address phase, write data after it
//   dbus_out registered read data
//   dbus_oe  read-data drive enable
interface bus8051_fir_if;
  logic       cs_n;
  logic [7:0] abus;
  logic       ale;
  logic       r_n;
  logic       w_n;
  logic [7:0] dbus_in;
  logic [7:0] dbus_out;
  logic       dbus_oe;

  modport master (output cs_n, abus, ale, r_n, w_n, dbus_in,
                  input  dbus_out, dbus_oe);
  modport slave  (input  cs_n, abus, ale, r_n, w_n, dbus_in,
                  output dbus_out, dbus_oe);
endinterface

// File: rtl/bus8051_fir.sv
// 8051 bus slave with a TAPS-deep sample history and a sequential masked
// FIR multiply-accumulate engine (one tap per clock).
//   clk      clock, rising edge
//   rst      synchronous reset, active high
//   bus      8051 multiplexed bus (slave modport)
//   pe_n     sample strobe, active low, one clk wide
//   sig_in   sample value (unsigned, DW bits)
//   y        last filter result (OW bits)
//   y_valid  one-cycle pulse when y updates
//   busy     MAC in progress
//
// FSM states:
//   state  | meaning
//   S_IDLE | waiting for a sample; pending history clear is applied here
//   S_MAC  | accumulating tap tap_idx, busy=1
//   S_DONE | publish acc to y, pulse y_valid, set rvalid
module bus8051_fir #(
  parameter int         TAPS    = 8,
  parameter int         DW      = 8,
  parameter int         CW      = 8,
  parameter logic [7:0] BASE_HI = 8'h00,
  localparam int        OW      = DW + CW + 4
) (
  input  logic          clk,
  input  logic          rst,
  bus8051_fir_if.slave  bus,
  input  logic          pe_n,
  input  logic [DW-1:0] sig_in,
  output logic [OW-1:0] y,
  output logic          y_valid,
  output logic          busy
);

  localparam logic [15:0] TAP_MASK = 16'((32'd1 << TAPS) - 1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

  state_t        state;
  logic          ale_q, w_n_q, r_n_q;
  logic [7:0]    din_q;
  logic [15:0]   addr_cap;
  logic [15:0]   addr;
  logic [CW-1:0] coef [TAPS];
  logic [DW-1:0] hist [TAPS];
  logic [15:0]   mask;
  logic          enable;
  logic          clr_hist_pend;
  logic          overrun;
  logic          rvalid;
  logic [OW-1:0] acc;
  logic [4:0]    tap_idx;

  logic          sel, hit, ale_fall, w_rise, r_fall;
  logic          accept, drop, wr_ctrl;
  logic [7:0]    lo;
  logic [7:0]    rdata;
  logic [31:0]   y_ext;
  logic [CW-1:0] cur_c;
  logic [DW-1:0] cur_x;
  logic          cur_m;
  logic [OW-1:0] term;

  assign sel      = ~bus.cs_n;
  assign lo       = addr[7:0];
  assign hit      = (addr[15:8] == BASE_HI);
  assign ale_fall = sel & ale_q & ~bus.ale;
  assign w_rise   = sel & ~w_n_q & bus.w_n;
  assign r_fall   = sel & r_n_q & ~bus.r_n;
  assign accept   = ~pe_n & enable & (state == S_IDLE);
  assign drop     = ~pe_n & enable & (state != S_IDLE);
  assign wr_ctrl  = w_rise & hit & (lo == 8'h22);
  assign y_ext    = 32'(y);

  // Current tap operands come straight from the live registers so that a
  // CPU update during MAC is used by every tap not yet processed.
  always_comb begin
    cur_c = '0;
    cur_x = '0;
    cur_m = 1'b0;
    for (int k = 0; k < TAPS; k++) begin
      if (tap_idx == 5'(k)) begin
        cur_c = coef[k];
        cur_x = hist[k];
        cur_m = mask[k];
      end
    end
    term = cur_m ? (OW'(cur_c) * OW'(cur_x)) : '0;
  end

  always_comb begin
    rdata = 8'h00;
    for (int k = 0; k < TAPS; k++) begin
      if (lo == 8'(k)) rdata = 8'(coef[k]);
    end
    case (lo)
      8'h20:   rdata = mask[7:0];
      8'h21:   rdata = mask[15:8];
      8'h22:   rdata = {7'b0, enable};
      8'h23:   rdata = {5'b0, rvalid, overrun, busy};
      8'h24:   rdata = y_ext[7:0];
      8'h25:   rdata = y_ext[15:8];
      8'h26:   rdata = y_ext[23:16];
      8'h27:   rdata = y_ext[31:24];
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      ale_q         <= 1'b0;
      w_n_q         <= 1'b1;
      r_n_q         <= 1'b1;
      din_q         <= '0;
      addr_cap      <= '0;
      addr          <= '0;
      mask          <= '0;
      enable        <= 1'b1;
      clr_hist_pend <= 1'b0;
      overrun       <= 1'b0;
      rvalid        <= 1'b0;
      acc           <= '0;
      tap_idx       <= '0;
      y             <= '0;
      y_valid       <= 1'b0;
      busy          <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        coef[k] <= '0;
        hist[k] <= '0;
      end
    end else begin
      ale_q   <= bus.ale;
      w_n_q   <= bus.w_n;
      r_n_q   <= bus.r_n;
      din_q   <= bus.dbus_in;
      y_valid <= 1'b0;

      if (sel && bus.ale) addr_cap <= {bus.abus, bus.dbus_in};
      if (ale_fall)       addr     <= addr_cap;

      if (r_fall && hit && lo == 8'h24) rvalid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (accept) begin
            hist[0] <= sig_in;
            for (int k = 1; k < TAPS; k++) begin
              hist[k] <= clr_hist_pend ? '0 : hist[k-1];
            end
            acc     <= '0;
            tap_idx <= '0;
            busy    <= 1'b1;
            state   <= S_MAC;
          end else if (clr_hist_pend) begin
            for (int k = 0; k < TAPS; k++) hist[k] <= '0;
          end
          clr_hist_pend <= 1'b0;
        end
        S_MAC: begin
          acc <= acc + term;
          if (tap_idx == 5'(TAPS - 1)) begin
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            tap_idx <= tap_idx + 5'd1;
          end
        end
        S_DONE: begin
          y       <= acc;
          y_valid <= 1'b1;
          rvalid  <= 1'b1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // Register writes come after the FSM so a fresh clear_history request
      // is not lost to the IDLE-state acknowledge in the same cycle.
      if (w_rise && hit) begin
        for (int k = 0; k < TAPS; k++) begin
          if (lo == 8'(k)) coef[k] <= din_q[CW-1:0];
        end
        if (lo == 8'h20) mask[7:0]  <= din_q & TAP_MASK[7:0];
        if (lo == 8'h21) mask[15:8] <= din_q & TAP_MASK[15:8];
        if (lo == 8'h22) begin
          enable <= din_q[0];
          if (din_q[1]) clr_hist_pend <= 1'b1;
        end
      end

      // A dropped sample wins over a simultaneous clear request.
      if (drop)                         overrun <= 1'b1;
      else if (wr_ctrl && din_q[2])     overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.dbus_oe  <= 1'b0;
      bus.dbus_out <= 8'h00;
    end else if (sel && !bus.r_n && hit) begin
      bus.dbus_oe  <= 1'b1;
      bus.dbus_out <= rdata;
    end else begin
      bus.dbus_oe  <= 1'b0;
      bus.dbus_out <= 8'h00;
    end
  end

endmodule

// File: tb/tb_bus8051_fir.sv
// Bench for bus8051_fir: bus readback, FIR results against a queue-based
// reference, mask/clear_history, overrun, enable and reset-abort behaviour.
module tb_bus8051_fir;
  localparam int TAPS = 8;
  localparam int DW   = 8;
  localparam int CW   = 8;
  localparam int OW   = DW + CW + 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pe_n = 1'b1;
  logic [DW-1:0] sig_in = '0;
  logic [OW-1:0] y;
  logic          y_valid;
  logic          busy;

  always #5 clk = ~clk;

  bus8051_fir_if bus ();

  bus8051_fir #(.TAPS(TAPS), .DW(DW), .CW(CW), .BASE_HI(8'h00)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .pe_n    (pe_n),
    .sig_in  (sig_in),
    .y       (y),
    .y_valid (y_valid),
    .busy    (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int unsigned m_coef [TAPS];
  int unsigned m_mask;
  int unsigned m_hist [$];
  bit          m_ovr;
  bit          m_rvalid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model_push(input int unsigned v);
    m_hist.push_front(v);
    if (m_hist.size() > TAPS) void'(m_hist.pop_back());
  endfunction

  function automatic int unsigned model_y();
    int unsigned s = 0;
    for (int k = 0; k < m_hist.size(); k++) begin
      if (((m_mask >> k) & 1) != 0) s += m_coef[k] * m_hist[k];
    end
    return s;
  endfunction

  function automatic logic [31:0] model_status();
    return {29'b0, m_rvalid, m_ovr, 1'b0};
  endfunction

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.cs_n = 1'b0; bus.ale = 1'b1; bus.abus = a[15:8]; bus.dbus_in = a[7:0];
    @(negedge clk);
    bus.ale = 1'b0; bus.dbus_in = d; bus.w_n = 1'b0;
    @(negedge clk);
    bus.w_n = 1'b1;
    @(negedge clk);
    bus.cs_n = 1'b1; bus.dbus_in = 8'h00;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d, output logic oe);
    @(negedge clk);
    bus.cs_n = 1'b0; bus.ale = 1'b1; bus.abus = a[15:8]; bus.dbus_in = a[7:0];
    @(negedge clk);
    bus.ale = 1'b0;
    @(negedge clk);
    bus.r_n = 1'b0;
    @(negedge clk);
    d = bus.dbus_out; oe = bus.dbus_oe;
    bus.r_n = 1'b1;
    @(negedge clk);
    bus.cs_n = 1'b1;
  endtask

  task automatic read_chk(input logic [15:0] a, input logic [7:0] exp, input logic exp_oe,
                          input string tag);
    logic [7:0] d;
    logic       oe;
    bus_read(a, d, oe);
    check({tag, "_data"}, 32'(d), 32'(exp));
    check({tag, "_oe"}, 32'(oe), 32'(exp_oe));
  endtask

  // Starts on a negedge, drives one sample and returns on the negedge where
  // y_valid is seen (or when the cycle budget runs out).
  task automatic run_sample(input int unsigned v, input string tag);
    int          cnt;
    int unsigned e;
    model_push(v);
    e        = model_y();
    m_rvalid = 1'b1;
    pe_n = 1'b0; sig_in = DW'(v);
    @(negedge clk);
    pe_n = 1'b1; cnt = 1;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    while (!y_valid && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check({tag, "_lat"}, cnt, TAPS + 2);
    check({tag, "_y"}, 32'(y), e);
  endtask

  initial begin
    logic [15:0] v16;
    logic [15:0] em;
    int unsigned v1, v2, e;
    int          nyv, first;
    logic [31:0] got;
    bit          seen_busy, seen_yv;

    bus.cs_n = 1'b1; bus.ale = 1'b0; bus.r_n = 1'b1; bus.w_n = 1'b1;
    bus.abus = 8'h00; bus.dbus_in = 8'h00;
    for (int k = 0; k < TAPS; k++) m_coef[k] = 0;
    m_mask = 0; m_ovr = 1'b0; m_rvalid = 1'b0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset state
    check("rst_y", 32'(y), 32'd0);
    check("rst_yv", 32'(y_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_oe", 32'(bus.dbus_oe), 32'd0);
    check("rst_dout", 32'(bus.dbus_out), 32'd0);
    read_chk(16'h0022, 8'h01, 1'b1, "rst_ctrl");
    read_chk(16'h0023, 8'h00, 1'b1, "rst_status");
    read_chk(16'h0000, 8'h00, 1'b1, "rst_coef0");

    // register readback and decode
    bus_write(16'h0003, 8'hA5);
    read_chk(16'h0003, 8'hA5, 1'b1, "rb_coef3");
    read_chk(16'h0030, 8'h00, 1'b1, "rb_unmapped");
    bus_write(16'h0103, 8'h5A);
    read_chk(16'h0003, 8'hA5, 1'b1, "rb_foreign_base");
    read_chk(16'h0103, 8'h00, 1'b0, "rb_nodecode");
    for (int k = 0; k < TAPS; k++) begin
      v1 = $urandom_range(0, 255);
      bus_write(16'(k), 8'(v1));
      read_chk(16'(k), 8'(v1), 1'b1, "rb_coef_rand");
    end
    v16 = 16'($urandom);
    em  = v16 & 16'((32'd1 << TAPS) - 1);
    bus_write(16'h0020, v16[7:0]);
    bus_write(16'h0021, v16[15:8]);
    read_chk(16'h0020, em[7:0], 1'b1, "rb_mask_lo");
    read_chk(16'h0021, em[15:8], 1'b1, "rb_mask_hi");

    // basic FIR
    for (int k = 0; k < TAPS; k++) begin
      m_coef[k] = (k < 4) ? k + 1 : 0;
      bus_write(16'(k), 8'(m_coef[k]));
    end
    m_mask = 32'h000F;
    bus_write(16'h0020, 8'h0F);
    bus_write(16'h0021, 8'h00);
    @(negedge clk);
    run_sample(65, "fir_s65");
    check("fir_first", 32'(y), 32'd65);
    run_sample(66, "fir_s66");
    run_sample(67, "fir_s67");
    run_sample(68, "fir_s68");
    check("fir_final", 32'(y), 32'd660);
    read_chk(16'h0023, 8'(model_status()), 1'b1, "fir_status_rv");
    read_chk(16'h0024, 8'h94, 1'b1, "fir_ybyte0");
    m_rvalid = 1'b0;
    read_chk(16'h0025, 8'h02, 1'b1, "fir_ybyte1");
    read_chk(16'h0026, 8'h00, 1'b1, "fir_ybyte2");
    read_chk(16'h0023, 8'(model_status()), 1'b1, "fir_status_clr");

    // mask + clear_history
    m_mask = 32'h0005;
    bus_write(16'h0020, 8'h05);
    bus_write(16'h0022, 8'h03);
    m_hist.delete();
    @(negedge clk);
    run_sample(0, "mask_zero");
    run_sample(65, "mask_s65");
    run_sample(66, "mask_s66");
    run_sample(67, "mask_s67");
    run_sample(68, "mask_s68");
    check("mask_final", 32'(y), 32'd266);

    // randomized coefficients, mask and samples
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < TAPS; k++) begin
        m_coef[k] = $urandom_range(0, 255);
        bus_write(16'(k), 8'(m_coef[k]));
      end
      m_mask = $urandom_range(0, 255);
      bus_write(16'h0020, 8'(m_mask));
      @(negedge clk);
      for (int s = 0; s < 5; s++) run_sample($urandom_range(0, 255), "rand");
    end

    // overrun: second pulse two cycles after the first
    v1 = $urandom_range(1, 255);
    v2 = $urandom_range(0, 255);
    model_push(v1);
    e = model_y();
    m_ovr = 1'b1; m_rvalid = 1'b1;
    @(negedge clk);
    pe_n = 1'b0; sig_in = DW'(v1);
    @(negedge clk);
    pe_n = 1'b1;
    @(negedge clk);
    pe_n = 1'b0; sig_in = DW'(v2);
    @(negedge clk);
    pe_n = 1'b1;
    nyv = 0; first = 0; got = '0;
    for (int i = 3; i < 30; i++) begin
      if (y_valid) begin
        nyv++;
        if (first == 0) begin
          first = i;
          got   = 32'(y);
        end
      end
      @(negedge clk);
    end
    check("ovr_count", nyv, 1);
    check("ovr_lat", first, TAPS + 2);
    check("ovr_y", got, e);
    read_chk(16'h0023, 8'(model_status()), 1'b1, "ovr_status");
    check("ovr_status_const", model_status(), 32'h06);
    bus_write(16'h0022, 8'h05);
    m_ovr = 1'b0;
    read_chk(16'h0023, 8'(model_status()), 1'b1, "ovr_cleared");

    // enable off: sample ignored entirely
    bus_write(16'h0022, 8'h00);
    read_chk(16'h0022, 8'h00, 1'b1, "en_ctrl_off");
    @(negedge clk);
    pe_n = 1'b0; sig_in = 8'd99;
    @(negedge clk);
    pe_n = 1'b1;
    seen_busy = 1'b0; seen_yv = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (busy)    seen_busy = 1'b1;
      if (y_valid) seen_yv   = 1'b1;
      @(negedge clk);
    end
    check("en_no_busy", 32'(seen_busy), 32'd0);
    check("en_no_yv", 32'(seen_yv), 32'd0);
    read_chk(16'h0023, 8'(model_status()), 1'b1, "en_status");
    bus_write(16'h0022, 8'h01);
    @(negedge clk);
    run_sample($urandom_range(0, 255), "en_resume");

    // reset in MAC cycle 3
    @(negedge clk);
    pe_n = 1'b0; sig_in = 8'd200;
    @(negedge clk);
    pe_n = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < TAPS; k++) m_coef[k] = 0;
    m_mask = 0; m_hist.delete(); m_ovr = 1'b0; m_rvalid = 1'b0;
    check("mrst_y", 32'(y), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_oe", 32'(bus.dbus_oe), 32'd0);
    check("mrst_dout", 32'(bus.dbus_out), 32'd0);
    seen_yv = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (y_valid) seen_yv = 1'b1;
      @(negedge clk);
    end
    check("mrst_no_yv", 32'(seen_yv), 32'd0);
    read_chk(16'h0022, 8'h01, 1'b1, "mrst_ctrl");
    read_chk(16'h0023, 8'(model_status()), 1'b1, "mrst_status");
    read_chk(16'h0001, 8'(m_coef[1]), 1'b1, "mrst_coef1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
